// File: rtl/mem_req_ctrl_pkg.sv
// rtl/mem_req_ctrl_pkg.sv - shared types and constants for the data-cache request controller
package mem_req_ctrl_pkg;

    // Bus transaction phases of the blocking request controller
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_req_state_t;

    // Level presented on cpu_busy when the pipeline must freeze
    localparam logic CACHEBUSY = 1'b1;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - MEM-stage request/response and SRAM-like bus signal bundle
interface mem_req_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // MEM stage side
    logic                cpu_req_valid;
    logic                cpu_req_wr;
    logic [1:0]          cpu_req_size;
    logic [ADDR_W-1:0]   cpu_req_addr;
    logic [DATA_W-1:0]   cpu_req_wdata;
    logic [DATA_W/8-1:0] cpu_req_wstrb;
    logic                cpu_flush;
    logic                cpu_busy;
    logic                cpu_data_ok;
    logic [DATA_W-1:0]   cpu_rdata;

    // SRAM-like bus side
    logic                bus_req;
    logic                bus_wr;
    logic [1:0]          bus_size;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W/8-1:0] bus_wstrb;
    logic                bus_addr_ok;
    logic                bus_data_ok;
    logic [DATA_W-1:0]   bus_rdata;

    // Controller view
    modport slave (
        input  cpu_req_valid, cpu_req_wr, cpu_req_size, cpu_req_addr,
               cpu_req_wdata, cpu_req_wstrb, cpu_flush,
               bus_addr_ok, bus_data_ok, bus_rdata,
        output cpu_busy, cpu_data_ok, cpu_rdata,
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb
    );

    // Pipeline plus memory view
    modport master (
        output cpu_req_valid, cpu_req_wr, cpu_req_size, cpu_req_addr,
               cpu_req_wdata, cpu_req_wstrb, cpu_flush,
               bus_addr_ok, bus_data_ok, bus_rdata,
        input  cpu_busy, cpu_data_ok, cpu_rdata,
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - blocking MEM-stage load/store responder with flush kill and stall counter
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_req_ctrl_if.slave    mif,
    output logic [CNT_W-1:0] stall_cnt
);

    mem_req_state_t      state_q;
    logic                killed_q;
    logic                req_q;
    logic                data_ok_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    stall_q;
    logic [CNT_W-1:0]    stall_d;
    logic                busy;

    // Freeze the pipeline while a live request is pending, and hold any new
    // request off while a killed transaction drains from the bus
    always_comb begin
        busy = ((state_q == IDLE) && mif.cpu_req_valid && !mif.cpu_flush)
             || (((state_q == REQ) || (state_q == WAIT)) && !killed_q)
             || (killed_q && mif.cpu_req_valid);
    end

    // Request FSM: latch request, hold it on the bus until accepted, wait for data,
    // and pulse completion unless the request was flushed along the way
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            killed_q  <= 1'b0;
            req_q     <= 1'b0;
            data_ok_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    killed_q <= 1'b0;
                    if (mif.cpu_req_valid && !mif.cpu_flush) begin
                        wr_q    <= mif.cpu_req_wr;
                        size_q  <= mif.cpu_req_size;
                        addr_q  <= mif.cpu_req_addr;
                        wdata_q <= mif.cpu_req_wdata;
                        wstrb_q <= mif.cpu_req_wstrb;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mif.cpu_flush) begin
                        killed_q <= 1'b1;
                    end
                    if (mif.bus_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mif.bus_data_ok) begin
                        if (killed_q || mif.cpu_flush) begin
                            killed_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            if (!wr_q) begin
                                rdata_q <= mif.bus_rdata;
                            end
                            data_ok_q <= 1'b1;
                            state_q   <= DONE;
                        end
                    end else if (mif.cpu_flush) begin
                        killed_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of frozen-pipeline cycles
    always_comb begin
        stall_d = stall_q;
        if (busy && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign mif.cpu_busy    = busy ? CACHEBUSY : ~CACHEBUSY;
    assign mif.cpu_data_ok = data_ok_q;
    assign mif.cpu_rdata   = rdata_q;
    assign mif.bus_req     = req_q;
    assign mif.bus_wr      = wr_q;
    assign mif.bus_size    = size_q;
    assign mif.bus_addr    = addr_q;
    assign mif.bus_wdata   = wdata_q;
    assign mif.bus_wstrb   = wstrb_q;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - scoreboard bench for mem_req_ctrl
module tb_mem_req_ctrl;
    import mem_req_ctrl_pkg::*;

    localparam int CNT_W     = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int          addr_delay;
        int          data_delay;
        logic [31:0] rdata;
    } rsp_cfg_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_exp_t;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] stall_cnt;

    mem_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_req_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mif       (mif),
        .stall_cnt (stall_cnt)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          accept_cnt  = 0;
    int          exp_accept  = 0;
    int          exp_stall   = 0;
    logic [31:0] last_rdata  = '0;

    rsp_cfg_t    rsp_q[$];
    bus_exp_t    bus_exp_q[$];
    logic [31:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > STALL_MAX) ? STALL_MAX : a + b;
    endfunction

    // Memory responder: per-transaction addr_ok / data_ok delays from rsp_q
    initial begin
        rsp_cfg_t cur;
        int       st;
        int       cnt;
        bit       have;
        st   = 0;
        cnt  = 0;
        have = 1'b0;
        cur  = '{0, 1, 32'h0};
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b0;
        mif.bus_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            mif.bus_addr_ok = 1'b0;
            mif.bus_data_ok = 1'b0;
            mif.bus_rdata   = $urandom;
            if (rst) begin
                st   = 0;
                cnt  = 0;
                have = 1'b0;
            end else if (st == 0) begin
                if (mif.bus_req) begin
                    if (!have) begin
                        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
                        else cur = '{0, 1, 32'h0};
                        have = 1'b1;
                        cnt  = 0;
                    end
                    if (cnt == cur.addr_delay) begin
                        mif.bus_addr_ok = 1'b1;
                        st  = 1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                cnt++;
                if (cnt == cur.data_delay) begin
                    mif.bus_data_ok = 1'b1;
                    mif.bus_rdata   = cur.rdata;
                    st   = 0;
                    have = 1'b0;
                end
            end
        end
    end

    // Bus-side monitor: request fields held while bus_req is up, one acceptance each
    always @(negedge clk) begin
        if (!rst && mif.bus_req) begin
            if (bus_exp_q.size() == 0) begin
                chk("bus_req_unexpected", 64'(mif.bus_req), 64'(0));
            end else begin
                chk("bus_addr",  64'(mif.bus_addr),  64'(bus_exp_q[0].addr));
                chk("bus_wdata", 64'(mif.bus_wdata), 64'(bus_exp_q[0].wdata));
                chk("bus_ctl",   64'({mif.bus_wr, mif.bus_size, mif.bus_wstrb}),
                    64'({bus_exp_q[0].wr, bus_exp_q[0].size, bus_exp_q[0].wstrb}));
                if (mif.bus_addr_ok) begin
                    void'(bus_exp_q.pop_front());
                    accept_cnt++;
                end
            end
        end
    end

    // CPU-side scoreboard: each completion pops the expected load data
    always @(negedge clk) begin
        if (!rst && mif.cpu_data_ok) begin
            if (sb_q.size() == 0) chk("cpu_data_ok_unexpected", 64'(mif.cpu_data_ok), 64'(0));
            else chk("cpu_rdata", 64'(mif.cpu_rdata), 64'(sb_q.pop_front()));
        end
    end

    task automatic drive_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        mif.cpu_req_valid = 1'b1;
        mif.cpu_req_wr    = wr;
        mif.cpu_req_size  = size;
        mif.cpu_req_addr  = addr;
        mif.cpu_req_wdata = wdata;
        mif.cpu_req_wstrb = wstrb;
        mif.cpu_flush     = 1'b0;
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        mif.cpu_req_valid = 1'b0;
        mif.cpu_flush     = 1'b0;
    endtask

    task automatic expect_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int ad, input int dd, input logic [31:0] rd);
        rsp_q.push_back('{ad, dd, rd});
        bus_exp_q.push_back('{wr, size, addr, wdata, wstrb});
        exp_accept++;
        if (!wr) last_rdata = rd;
        sb_q.push_back(last_rdata);
    endtask

    // One unflushed transaction; busy for 2+ad+dd cycles, then one DONE cycle
    task automatic do_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int ad, input int dd, input logic [31:0] rd);
        int lat;
        lat = 2 + ad + dd;
        expect_txn(wr, size, addr, wdata, wstrb, ad, dd, rd);
        @(posedge clk);
        #1;
        drive_req(wr, size, addr, wdata, wstrb);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            chk("cpu_busy",    64'(mif.cpu_busy),    64'(i < lat));
            chk("cpu_data_ok", 64'(mif.cpu_data_ok), 64'(i == lat));
        end
        exp_stall = sat_add(exp_stall, lat);
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mif.cpu_req_valid = 1'b0;
        mif.cpu_req_wr    = 1'b0;
        mif.cpu_req_size  = 2'd0;
        mif.cpu_req_addr  = '0;
        mif.cpu_req_wdata = '0;
        mif.cpu_req_wstrb = '0;
        mif.cpu_flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",    64'(mif.cpu_busy),    64'(0));
        chk("rst_data_ok", 64'(mif.cpu_data_ok), 64'(0));
        chk("rst_bus_req", 64'(mif.bus_req),     64'(0));
        chk("rst_rdata",   64'(mif.cpu_rdata),   64'(0));
        chk("rst_addr",    64'(mif.bus_addr),    64'(0));
        chk("rst_stall",   64'(stall_cnt),       64'(0));

        // 1: minimum-latency load
        do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF);
        drop_req();

        // 2: byte store, addr_ok held off 5 cycles
        do_req(1'b1, 2'd0, 32'h8000_0021, 32'h0000_AB00, 4'b0010, 5, 1, 32'h0);
        drop_req();
        chk("accepts_t2", 64'(accept_cnt), 64'(exp_accept));

        // 3: flush in WAIT, next load drains then completes; counter saturates
        begin
            logic [31:0] old_rdata;
            old_rdata = last_rdata;
            rsp_q.push_back('{0, 4, 32'h1111_2222});
            bus_exp_q.push_back('{1'b0, 2'd2, 32'h8000_0020, 32'h0, 4'h0});
            exp_accept++;
            @(posedge clk);
            #1;
            drive_req(1'b0, 2'd2, 32'h8000_0020, 32'h0, 4'h0);
            @(negedge clk);
            chk("t3_busy_T", 64'(mif.cpu_busy), 64'(1));
            @(negedge clk);
            chk("t3_bus_req", 64'(mif.bus_req), 64'(1));
            @(posedge clk);
            #1;
            mif.cpu_flush = 1'b1;
            @(negedge clk);
            chk("t3_busy_flush", 64'(mif.cpu_busy), 64'(1));
            expect_txn(1'b0, 2'd2, 32'h8000_0030, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D);
            @(posedge clk);
            #1;
            drive_req(1'b0, 2'd2, 32'h8000_0030, 32'h0, 4'h0);
            for (int i = 0; i <= 6; i++) begin
                @(negedge clk);
                chk("t3_busy",    64'(mif.cpu_busy),    64'(i < 6));
                chk("t3_data_ok", 64'(mif.cpu_data_ok), 64'(i == 6));
                if (i < 4) chk("t3_rdata_held", 64'(mif.cpu_rdata), 64'(old_rdata));
            end
            exp_stall = sat_add(exp_stall, 9);
            chk("t3_stall_sat", 64'(stall_cnt), 64'(exp_stall));
            drop_req();
            chk("accepts_t3", 64'(accept_cnt), 64'(exp_accept));
        end

        // 4: flush together with valid in IDLE issues nothing
        @(posedge clk);
        #1;
        drive_req(1'b0, 2'd2, 32'h8000_0040, 32'h0, 4'h0);
        mif.cpu_flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_busy",    64'(mif.cpu_busy), 64'(0));
            chk("t4_bus_req", 64'(mif.bus_req),  64'(0));
            chk("t4_stall",   64'(stall_cnt),    64'(exp_stall));
        end
        drop_req();

        // 5: back-to-back loads
        do_req(1'b0, 2'd2, 32'h0000_0000, 32'h0, 4'h0, 0, 1, 32'h0123_4567);
        do_req(1'b0, 2'd2, 32'h0000_0004, 32'h0, 4'h0, 0, 1, 32'h89AB_CDEF);
        drop_req();
        repeat (2) @(negedge clk);
        chk("accepts_t5", 64'(accept_cnt), 64'(exp_accept));

        // 6: reset while in REQ
        rsp_q.push_back('{10, 1, 32'h7777_7777});
        bus_exp_q.push_back('{1'b0, 2'd2, 32'h8000_0050, 32'h0, 4'h0});
        @(posedge clk);
        #1;
        drive_req(1'b0, 2'd2, 32'h8000_0050, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_bus_req_before", 64'(mif.bus_req), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        mif.cpu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_state",   64'(dut.state_q),  64'(IDLE));
        chk("t6_bus_req", 64'(mif.bus_req),  64'(0));
        chk("t6_busy",    64'(mif.cpu_busy), 64'(0));
        chk("t6_stall",   64'(stall_cnt),    64'(0));
        bus_exp_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall  = 0;
        last_rdata = '0;
        do_req(1'b0, 2'd1, 32'h8000_0062, 32'h0, 4'h0, 1, 2, 32'h5A5A_A5A5);
        drop_req();
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
